coletor_digitos: RTL and testbench
==================================

# coletor_digitos

Keypad digit collector that sits directly upstream of the setup and operation FSMs. It accepts one decoded key code per event and shifts digits into a 20-digit buffer. On `*` or `#` it emits one `senhaPac_t` word with a single-cycle `digitos_valid` pulse. Partial entries are discarded after an inactivity timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 5000: idle cycles after the last accepted key before a partial entry is discarded; must be ≥ 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: collector active; low clears and freezes it.
- `key_code` in 4: decoded key; 0x0–0x9 digit, 0xA `*` (confirm), 0xB `#` (special/skip), 0xC–0xF ignored.
- `key_valid` in 1: one-cycle strobe qualifying `key_code`.
- `digitos_value` out `senhaPac_t` (20×4): last emitted word, registered.
- `digitos_valid` out 1: one-cycle pulse; `digitos_value` is new in the same cycle.
- `digitos_live` out `senhaPac_t`: current buffer contents, for display echo.
- `digitos_count` out 5: digits currently buffered, 0–20.

## Operation
- Buffer layout: index 0 holds the most recent digit, higher indices hold older digits. Unused positions hold 0xF.
  - Example: typing 1,2,3,4 gives `{16{F},1,2,3,4}`.
- States:
  - DISABLED: entered when `enable`=0. Buffer is all 0xF, count=0, timer stopped, keys ignored.
  - EMPTY: `enable`=1 and count=0.
  - COLLECTING: count ≥ 1.
  - EMIT: one cycle, asserts `digitos_valid`; always returns to EMPTY.
- Digit key, from EMPTY or COLLECTING:
  - buffer ← {buffer[18:0], digit}, i.e. shift toward higher indices and insert at index 0.
  - count ← min(count+1, 20). At count 20 the oldest digit (index 19) is dropped.
  - Timer reloads.
- `*` key:
  - `digitos_value` ← buffer; go to EMIT.
  - Buffer ← all 0xF, count ← 0.
  - `*` with an empty buffer still emits an all-0xF word.
- `#` key:
  - `digitos_value` ← `{20{4'hB}}`; go to EMIT.
  - Buffer cleared and count ← 0.
- Keys 0xC–0xF: no effect, timer not reloaded.
- Keys presented during EMIT are ignored.
- Timeout: in COLLECTING, the timer decrements each cycle. When it reaches 0: buffer cleared, count ← 0, go to EMPTY, no valid pulse.
- Priorities:
  - `enable`=0 beats everything, including a same-cycle key.
  - A key accepted in the expiry cycle beats the timeout: the key is processed and the timer reloads.

## Timing
- Reset values:
  - `digitos_value` = all 0xF.
  - `digitos_live` = all 0xF.
  - `digitos_valid` = 0, `digitos_count` = 0.
  - State is DISABLED until the first edge with `enable`=1.
- Latency:
  - A key strobed at edge N updates `digitos_live`/`digitos_count` visibly after edge N.
  - For `*`/`#` at edge N, `digitos_valid`=1 for exactly the cycle between edges N and N+1.
- `digitos_value` holds between pulses; downstream may sample it at any time.
- Timer:
  - Counter width is $clog2(TIMEOUT_CYCLES+1), reloaded to TIMEOUT_CYCLES.
  - Expiry happens TIMEOUT_CYCLES cycles after the last accepted digit.
- Disabling during EMIT: the pulse already issued completes, then the block goes to DISABLED.
- Reset mid-entry: everything returns to reset values immediately (asynchronous).

## Structure
- Shared package (Tipos.sv): `senhaPac_t`, `NUM_DIGITOS`=20, `KEY_STAR`=4'hA, `KEY_HASH`=4'hB, `DIGITO_VAZIO`=4'hF.
- One sub-module, `contador_timeout`:
  - Inputs: reload, run.
  - Output: expire, a one-cycle pulse.
  - Parameterised by TIMEOUT_CYCLES.
- Everything else (FSM, buffer) lives in `coletor_digitos`.

## Test plan
- Reset, enable, keys 1,2,3,4,`*`:
  - One `digitos_valid` pulse with `digitos_value` = `{16{F},1,2,3,4}`.
  - Then count=0 and `digitos_live` = all F.
- Keys 0–9 then 0–9 then 7,8,`*` (22 digits):
  - Emitted word holds only the last 20 digits, index 0 = 8, index 19 = 2.
  - Count saturates at 20.
- `#` alone: emits `{20{4'hB}}`. Then `*` alone: emits all F. Each is exactly one pulse.
- TIMEOUT_CYCLES=10, keys 5,6, then idle 10 cycles:
  - Buffer cleared, no pulse.
  - Re-run with a key landing on the expiry cycle: the key is kept and count is correct.
- Keys 3,9, then `enable`=0 for one cycle coincident with `*`:
  - No pulse, buffer cleared.
  - After re-enable, `*` emits all F.
- Key 0xC and key strobes during EMIT: ignored. Assert `rst` mid-entry: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/coletor_digitos_pkg.sv
// Shared keypad types: packed password word, key codes and collector FSM states.
// Digit index 0 is always the most recent key.
package coletor_digitos_pkg;

    localparam int NUM_DIGITOS = 20;
    localparam int COUNT_W     = $clog2(NUM_DIGITOS + 1);

    localparam logic [3:0] KEY_STAR     = 4'hA;
    localparam logic [3:0] KEY_HASH     = 4'hB;
    localparam logic [3:0] DIGITO_VAZIO = 4'hF;

    typedef logic [NUM_DIGITOS-1:0][3:0] senhaPac_t;
    typedef logic [COUNT_W-1:0]          count_t;

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_EMPTY,
        ST_COLLECTING,
        ST_EMIT
    } coletor_state_e;

    localparam senhaPac_t SENHA_VAZIA    = {NUM_DIGITOS{DIGITO_VAZIO}};
    localparam senhaPac_t SENHA_ESPECIAL = {NUM_DIGITOS{KEY_HASH}};
    localparam count_t    COUNT_MAX      = COUNT_W'(NUM_DIGITOS);

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    // New digit enters at index 0; the digit at the top index falls off.
    function automatic senhaPac_t push_digit(input senhaPac_t buf_in, input logic [3:0] digit);
        return {buf_in[NUM_DIGITOS-2:0], digit};
    endfunction

endpackage

// File: rtl/coletor_digitos_timeout.sv
// Inactivity down-counter: reload sets it to TIMEOUT_CYCLES, run counts it down.
// expire pulses for the single cycle in which the count sits at 1 while running.
module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic run,
    output logic expire
);

    localparam int            CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = RELOAD_VAL;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Independent of reload so the parent can let a same-cycle key win.
    assign expire = run && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/coletor_digitos.sv
// Keypad digit collector: shifts digits into a 20-digit buffer, emits a word on '*'/'#'.
// Partial entries are dropped after TIMEOUT_CYCLES idle cycles; enable=0 clears everything.
import coletor_digitos_pkg::*;

module coletor_digitos #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid,
    output senhaPac_t  digitos_live,
    output logic [4:0] digitos_count
);

    coletor_state_e state_q, state_d;
    senhaPac_t      buf_q, buf_d;
    senhaPac_t      value_q, value_d;
    count_t         count_q, count_d;

    logic timer_reload;
    logic timer_run;
    logic timer_expire;

    assign timer_run = (state_q == ST_COLLECTING);

    contador_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .reload (timer_reload),
        .run    (timer_run),
        .expire (timer_expire)
    );

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        count_d      = count_q;
        value_d      = value_q;
        timer_reload = 1'b0;

        unique case (state_q)
            ST_DISABLED: begin
                buf_d   = SENHA_VAZIA;
                count_d = '0;
                if (enable) begin
                    state_d = ST_EMPTY;
                end
            end

            ST_EMPTY, ST_COLLECTING: begin
                if (!enable) begin
                    buf_d   = SENHA_VAZIA;
                    count_d = '0;
                    state_d = ST_DISABLED;
                end else if (key_valid && is_digit(key_code)) begin
                    buf_d        = push_digit(buf_q, key_code);
                    count_d      = (count_q == COUNT_MAX) ? count_q : count_q + count_t'(1);
                    timer_reload = 1'b1;
                    state_d      = ST_COLLECTING;
                end else if (key_valid && (key_code == KEY_STAR)) begin
                    value_d = buf_q;
                    buf_d   = SENHA_VAZIA;
                    count_d = '0;
                    state_d = ST_EMIT;
                end else if (key_valid && (key_code == KEY_HASH)) begin
                    value_d = SENHA_ESPECIAL;
                    buf_d   = SENHA_VAZIA;
                    count_d = '0;
                    state_d = ST_EMIT;
                end else if ((state_q == ST_COLLECTING) && timer_expire) begin
                    // Keys 0xC-0xF land here too: they never refresh the timer.
                    buf_d   = SENHA_VAZIA;
                    count_d = '0;
                    state_d = ST_EMPTY;
                end
            end

            ST_EMIT: begin
                // Buffer was already cleared on entry; keys here are dropped.
                state_d = enable ? ST_EMPTY : ST_DISABLED;
            end

            default: begin
                buf_d   = SENHA_VAZIA;
                count_d = '0;
                state_d = ST_DISABLED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DISABLED;
            buf_q   <= SENHA_VAZIA;
            value_q <= SENHA_VAZIA;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign digitos_value = value_q;
    assign digitos_valid = (state_q == ST_EMIT);
    assign digitos_live  = buf_q;
    assign digitos_count = count_q;

endmodule

// File: tb/tb_coletor_digitos.sv
// Self-checking bench for coletor_digitos with a queue-based reference model.
// Uses TIMEOUT_CYCLES=10 so expiry scenarios stay short.
import coletor_digitos_pkg::*;

module tb_coletor_digitos;

    localparam int T = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] key_code;
    logic       key_valid;
    senhaPac_t  digitos_value;
    logic       digitos_valid;
    senhaPac_t  digitos_live;
    logic [4:0] digitos_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0] q[$];
    bit         m_active;
    bit         m_emit;
    int         m_idle;
    senhaPac_t  m_value;

    coletor_digitos #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .key_code      (key_code),
        .key_valid     (key_valid),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid),
        .digitos_live  (digitos_live),
        .digitos_count (digitos_count)
    );

    always #5 clk = ~clk;

    function automatic senhaPac_t pack_q();
        senhaPac_t r;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            r[i] = (i < q.size()) ? q[i] : 4'hF;
        end
        return r;
    endfunction

    function automatic senhaPac_t all_of(input logic [3:0] d);
        senhaPac_t r;
        for (int i = 0; i < NUM_DIGITOS; i++) r[i] = d;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_active = 0;
        m_emit   = 0;
        m_idle   = 0;
        m_value  = all_of(4'hF);
    endtask

    // One clock edge worth of behaviour, phrased in terms of the key stream.
    task automatic model_step(input bit en, input bit kv, input logic [3:0] kc);
        bit was_emit;
        was_emit = m_emit;
        m_emit   = 0;
        if (!m_active) begin
            if (en) m_active = 1;
        end else if (was_emit) begin
            if (!en) m_active = 0;
        end else if (!en) begin
            m_active = 0;
            q.delete();
        end else if (kv && kc <= 4'd9) begin
            q.push_front(kc);
            if (q.size() > NUM_DIGITOS) void'(q.pop_back());
            m_idle = 0;
        end else if (kv && kc == 4'hA) begin
            m_value = pack_q();
            q.delete();
            m_emit = 1;
        end else if (kv && kc == 4'hB) begin
            m_value = all_of(4'hB);
            q.delete();
            m_emit = 1;
        end else if (q.size() > 0) begin
            m_idle++;
            if (m_idle == T) q.delete();
        end
    endtask

    task automatic tick(input bit en, input bit kv, input logic [3:0] kc);
        @(negedge clk);
        enable    = en;
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        model_step(en, kv, kc);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (digitos_value !== all_of(4'hF) || digitos_live !== all_of(4'hF) ||
            digitos_valid !== 1'b0 || digitos_count !== 5'd0) begin
            errors++;
            $display("FAIL reset: value=%h live=%h valid=%b count=%0d, want all F/all F/0/0",
                     digitos_value, digitos_live, digitos_valid, digitos_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [3:0] keys [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hA};
        senhaPac_t  want;
        int pulses = 0;
        want = {{16{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4};
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, i != 0, keys[i]);
            pulses += digitos_valid;
            checks++;
            if (digitos_valid !== m_emit || digitos_count !== 5'(q.size()) ||
                digitos_live !== pack_q() || digitos_value !== m_value) begin
                errors++;
                $display("FAIL basic step %0d: valid=%b count=%0d live=%h value=%h, want %b %0d %h %h",
                         i, digitos_valid, digitos_count, digitos_live, digitos_value,
                         m_emit, q.size(), pack_q(), m_value);
            end
        end
        tick(1'b1, 1'b0, 4'h0);
        pulses += digitos_valid;
        checks++;
        if (pulses != 1 || digitos_value !== want || digitos_count !== 5'd0 || digitos_live !== all_of(4'hF)) begin
            errors++;
            $display("FAIL basic_word: pulses=%0d value=%h count=%0d live=%h, want 1 %h 0 all F",
                     pulses, digitos_value, digitos_count, digitos_live, want);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 22; i++) begin
            logic [3:0] d;
            d = (i < 20) ? 4'(i % 10) : ((i == 20) ? 4'h7 : 4'h8);
            tick(1'b1, 1'b1, d);
            checks++;
            if (digitos_count !== 5'(q.size()) || digitos_live !== pack_q()) begin
                errors++;
                $display("FAIL saturate step %0d: count=%0d live=%h, want %0d %h",
                         i, digitos_count, digitos_live, q.size(), pack_q());
            end
        end
        checks++;
        if (digitos_count !== 5'd20) begin
            errors++;
            $display("FAIL saturate_count: count=%0d, want 20", digitos_count);
        end
        tick(1'b1, 1'b1, 4'hA);
        checks++;
        if (digitos_valid !== 1'b1 || digitos_value[0] !== 4'h8 || digitos_value[19] !== 4'h2 ||
            digitos_value !== m_value) begin
            errors++;
            $display("FAIL saturate_word: valid=%b value=%h, want 1 %h (idx0=8 idx19=2)",
                     digitos_valid, digitos_value, m_value);
        end
        tick(1'b1, 1'b0, 4'h0);
    endtask

    task automatic test_hash_star();
        logic [3:0] keys [4] = '{4'hB, 4'h0, 4'hA, 4'h0};
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, (i % 2) == 0, keys[i]);
            pulses += digitos_valid;
            checks++;
            if (digitos_valid !== m_emit || digitos_value !== m_value || digitos_count !== 5'(q.size())) begin
                errors++;
                $display("FAIL hash_star step %0d: valid=%b value=%h count=%0d, want %b %h %0d",
                         i, digitos_valid, digitos_value, digitos_count, m_emit, m_value, q.size());
            end
            if (i == 0) begin
                checks++;
                if (digitos_value !== all_of(4'hB)) begin
                    errors++;
                    $display("FAIL hash_word: value=%h, want all B", digitos_value);
                end
            end
        end
        checks++;
        if (pulses != 2 || digitos_value !== all_of(4'hF)) begin
            errors++;
            $display("FAIL hash_star_pulses: pulses=%0d value=%h, want 2 all F", pulses, digitos_value);
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        tick(1'b1, 1'b1, 4'h5);
        tick(1'b1, 1'b1, 4'h6);
        for (int i = 1; i <= T; i++) begin
            tick(1'b1, 1'b0, 4'h0);
            pulses += digitos_valid;
            checks++;
            if (digitos_count !== 5'(q.size()) || digitos_live !== pack_q()) begin
                errors++;
                $display("FAIL timeout idle %0d: count=%0d live=%h, want %0d %h",
                         i, digitos_count, digitos_live, q.size(), pack_q());
            end
        end
        checks++;
        if (digitos_count !== 5'd0 || digitos_live !== all_of(4'hF) || pulses != 0) begin
            errors++;
            $display("FAIL timeout_clear: count=%0d live=%h pulses=%0d, want 0 all F 0",
                     digitos_count, digitos_live, pulses);
        end
        // Key arriving exactly on the expiry edge must survive.
        tick(1'b1, 1'b1, 4'h5);
        tick(1'b1, 1'b1, 4'h6);
        repeat (T - 1) tick(1'b1, 1'b0, 4'h0);
        tick(1'b1, 1'b1, 4'h7);
        checks++;
        if (digitos_count !== 5'd3 || digitos_live !== {{17{4'hF}}, 4'h5, 4'h6, 4'h7}) begin
            errors++;
            $display("FAIL timeout_race: count=%0d live=%h, want 3 ...567", digitos_count, digitos_live);
        end
        repeat (T) tick(1'b1, 1'b0, 4'h0);
        checks++;
        if (digitos_count !== 5'd0 || digitos_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after_race: count=%0d valid=%b, want 0 0", digitos_count, digitos_valid);
        end
    endtask

    task automatic test_disable();
        tick(1'b1, 1'b1, 4'h3);
        tick(1'b1, 1'b1, 4'h9);
        tick(1'b0, 1'b1, 4'hA);
        checks++;
        if (digitos_valid !== 1'b0 || digitos_count !== 5'd0 || digitos_live !== all_of(4'hF)) begin
            errors++;
            $display("FAIL disable_star: valid=%b count=%0d live=%h, want 0 0 all F",
                     digitos_valid, digitos_count, digitos_live);
        end
        tick(1'b1, 1'b0, 4'h0);
        tick(1'b1, 1'b1, 4'hA);
        checks++;
        if (digitos_valid !== 1'b1 || digitos_value !== all_of(4'hF)) begin
            errors++;
            $display("FAIL reenable_star: valid=%b value=%h, want 1 all F", digitos_valid, digitos_value);
        end
        tick(1'b1, 1'b0, 4'h0);
    endtask

    task automatic test_ignored();
        bit         en   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] keys [7] = '{4'h1, 4'hC, 4'hA, 4'h5, 4'hB, 4'h3, 4'h4};
        for (int i = 0; i < 7; i++) begin
            tick(en[i], 1'b1, keys[i]);
            checks++;
            if (digitos_valid !== m_emit || digitos_count !== 5'(q.size()) ||
                digitos_live !== pack_q() || digitos_value !== m_value) begin
                errors++;
                $display("FAIL ignored step %0d: valid=%b count=%0d live=%h value=%h, want %b %0d %h %h",
                         i, digitos_valid, digitos_count, digitos_live, digitos_value,
                         m_emit, q.size(), pack_q(), m_value);
            end
        end
        checks++;
        if (digitos_value !== all_of(4'hB) || digitos_count !== 5'd0) begin
            errors++;
            $display("FAIL ignored_final: value=%h count=%0d, want all B 0", digitos_value, digitos_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit         en, kv;
            logic [3:0] kc;
            en = ($urandom_range(0, 39) != 0);
            kv = ($urandom_range(0, 9) < 3);
            kc = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            tick(en, kv, kc);
            checks++;
            if (digitos_valid !== m_emit || digitos_count !== 5'(q.size()) ||
                digitos_live !== pack_q() || digitos_value !== m_value) begin
                errors++;
                $display("FAIL random cycle %0d: valid=%b count=%0d live=%h value=%h, want %b %0d %h %h",
                         i, digitos_valid, digitos_count, digitos_live, digitos_value,
                         m_emit, q.size(), pack_q(), m_value);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b1, 4'h8);
        tick(1'b1, 1'b1, 4'h2);
        tick(1'b1, 1'b1, 4'hB);
        tick(1'b1, 1'b1, 4'h6);
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (digitos_value !== all_of(4'hF) || digitos_live !== all_of(4'hF) ||
            digitos_valid !== 1'b0 || digitos_count !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: value=%h live=%h valid=%b count=%0d, want all F/all F/0/0",
                     digitos_value, digitos_live, digitos_valid, digitos_count);
        end
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        tick(1'b1, 1'b1, 4'h4);
        tick(1'b1, 1'b1, 4'h4);
        checks++;
        if (digitos_count !== 5'd1 || digitos_live !== pack_q()) begin
            errors++;
            $display("FAIL post_reset: count=%0d live=%h, want 1 %h", digitos_count, digitos_live, pack_q());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_hash_star();
        test_timeout();
        test_disable();
        test_ignored();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
